router_fsm_nch: RTL and testbench
=================================

# router_fsm_nch

Parametrised packet-router controller FSM for a 1×NUM_CH router. It sits between the input register block, the synchroniser and the per-channel output FIFOs, and sequences header decode, payload load, FIFO-full stall, parity load and parity check. Compared with the fixed 3-channel controller, it adds the following:
- N channels.
- A latched destination, so empty checks and soft reset consider only the addressed channel.
- Silent drop of packets carrying an out-of-range address.

## Interface
Parameters:
- NUM_CH, 3, number of output channels (1..2**ADDR_W).
- ADDR_W, 2, width of header address field (data_in[ADDR_W-1:0]).

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous, active-low reset.
- pkt_valid  in  1  packet byte valid from source; low on the parity byte.
- data_in  in  ADDR_W  header address bits of the current byte.
- fifo_full  in  1  full flag of the currently selected FIFO.
- fifo_empty  in  NUM_CH  per-channel FIFO empty flags.
- soft_reset  in  NUM_CH  per-channel read-timeout soft resets.
- parity_done  in  1  parity byte has been captured by register block.
- low_packet_valid  in  1  pkt_valid fell while FIFO was full.
- detect_add  out  1  state DECODE_ADDRESS.
- lfd_state  out  1  state LOAD_FIRST_DATA.
- ld_state  out  1  state LOAD_DATA.
- laf_state  out  1  state LOAD_AFTER_FULL.
- full_state  out  1  state FIFO_FULL_STATE.
- write_enb_reg  out  1  LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- rst_int_reg  out  1  state CHECK_PARITY_ERROR.
- busy  out  1  source must hold its byte.
- drop_state  out  1  state DROP_PACKET or DROP_PARITY.
- dest  out  ADDR_W  latched destination channel.
- addr_err  out  1  one-cycle pulse on an out-of-range header.

## Operation
- State register is 4 bits and Moore; all outputs decode from present state PS, except `dest`, which is a register.
- States: DECODE_ADDRESS, LOAD_FIRST_DATA, LOAD_DATA, WAIT_TILL_EMPTY, CHECK_PARITY_ERROR, LOAD_PARITY, FIFO_FULL_STATE, LOAD_AFTER_FULL, DROP_PACKET, DROP_PARITY.
- `dest` latch: `dest <= data_in` when PS=DECODE_ADDRESS and pkt_valid=1; held otherwise.
- DECODE_ADDRESS, in priority order:
  - pkt_valid=0 → stay.
  - data_in ≥ NUM_CH → DROP_PACKET, and `addr_err` pulses for one cycle.
  - fifo_empty[data_in]=1 → LOAD_FIRST_DATA.
  - otherwise → WAIT_TILL_EMPTY.
- LOAD_FIRST_DATA → LOAD_DATA.
- LOAD_DATA:
  - fifo_full → FIFO_FULL_STATE.
  - else !pkt_valid → LOAD_PARITY.
  - else stay.
- WAIT_TILL_EMPTY: fifo_empty[dest] → LOAD_FIRST_DATA, else stay. Only the addressed channel is examined.
- LOAD_PARITY → CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: fifo_full → FIFO_FULL_STATE, else DECODE_ADDRESS.
- FIFO_FULL_STATE: !fifo_full → LOAD_AFTER_FULL, else stay.
- LOAD_AFTER_FULL:
  - parity_done → DECODE_ADDRESS.
  - else low_packet_valid → LOAD_PARITY.
  - else → LOAD_DATA.
- DROP_PACKET: pkt_valid=0 → DROP_PARITY, else stay. Bytes are accepted and discarded; write_enb_reg=0.
- DROP_PARITY → DECODE_ADDRESS. This state consumes the parity byte.
- busy=1 in LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_PARITY, CHECK_PARITY_ERROR, FIFO_FULL_STATE and LOAD_AFTER_FULL. It is 0 in DECODE_ADDRESS, LOAD_DATA, DROP_PACKET and DROP_PARITY.
- Soft reset: soft_reset[dest]=1 forces PS → DECODE_ADDRESS on the next edge. soft_reset on other channels is ignored.
- In DECODE_ADDRESS and the drop states, soft_reset is ignored, because no valid destination is owned.
- Unused encodings → DECODE_ADDRESS.

## Timing
- Reset: resetn=0 at an edge gives PS=DECODE_ADDRESS and dest=0. Resulting outputs: detect_add=1; all other outputs 0.
- Reset applies mid-packet from any state. It has priority over soft_reset, and soft_reset has priority over next-state logic.
- Header in DECODE_ADDRESS with an empty FIFO: lfd_state=1 the next cycle, ld_state=1 the cycle after.
- Minimum packet with no stall: header, then 1 payload byte, then parity. This takes 5 cycles from header to the return of detect_add: DA, LFD, LD, LP, CPE.
- addr_err is high exactly while PS=DROP_PACKET on the first cycle after the header edge, for 1 cycle only.
- fifo_full sampled in LOAD_DATA reaches full_state on the next cycle; a write is never issued from FIFO_FULL_STATE.
- Simultaneous fifo_full and !pkt_valid in LOAD_DATA: FIFO_FULL_STATE wins.
- NUM_CH = 2**ADDR_W: the out-of-range branch is never taken.

## Test plan
- Reset, then a header to ch1 with fifo_empty=3'b111, 3 payload bytes, and parity. Required state sequence: DA, LFD, LD×3, LP, CPE, DA. Required signals: write_enb_reg high 4 cycles; rst_int_reg high 1 cycle; dest=1.
- Header to ch2 with fifo_empty=3'b011 → WAIT_TILL_EMPTY, busy=1. Then set fifo_empty=3'b111 → LFD the next cycle. Setting ch0 or ch1 non-empty must not block this.
- Header data_in=3 with NUM_CH=3 → DROP_PACKET and addr_err one pulse. Then 4 bytes with write_enb_reg=0 and busy=0, then pkt_valid low → DROP_PARITY → DA.
- fifo_full asserted in LD → FULL_STATE, busy=1. Release it with low_packet_valid=1 and parity_done=0 → LAF → LP → CPE → DA.
- soft_reset=3'b010 while dest=0 in WAIT_TILL_EMPTY → no effect. Then soft_reset=3'b001 → DA on the next edge.
- resetn=0 in the middle of LOAD_DATA → DA, dest=0, all outputs except detect_add low.
- NUM_CH=4, ADDR_W=2 build: a header to ch3 completes normally; addr_err never asserts.

Source files
------------

// File: rtl/router_fsm_nch_if.sv
// Bus between the 1xNUM_CH router controller and the datapath blocks around it
// (register block, synchroniser, per-channel FIFOs).
interface router_fsm_nch_if #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic [ADDR_W-1:0] data_in;
  logic              fifo_full;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] soft_reset;
  logic              parity_done;
  logic              low_packet_valid;

  logic              detect_add;
  logic              lfd_state;
  logic              ld_state;
  logic              laf_state;
  logic              full_state;
  logic              write_enb_reg;
  logic              rst_int_reg;
  logic              busy;
  logic              drop_state;
  logic [ADDR_W-1:0] dest;
  logic              addr_err;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    input  detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, drop_state, dest, addr_err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset,
           parity_done, low_packet_valid,
    output detect_add, lfd_state, ld_state, laf_state, full_state,
           write_enb_reg, rst_int_reg, busy, drop_state, dest, addr_err
  );
endinterface

// File: rtl/router_fsm_nch.sv
// Packet-router controller for a 1xNUM_CH router: header decode, payload load,
// FIFO-full stall, parity load/check, and silent drop of out-of-range headers.
//
// state              | meaning
// -------------------+-------------------------------------------------------
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header written to the addressed FIFO
// LOAD_DATA          | streaming payload bytes
// WAIT_TILL_EMPTY    | addressed FIFO still draining a previous packet
// CHECK_PARITY_ERROR | parity compared, internal registers cleared
// LOAD_PARITY        | parity byte written
// FIFO_FULL_STATE    | stalled on a full FIFO, no write
// LOAD_AFTER_FULL    | writes the byte held during the stall
// DROP_PACKET        | discarding bytes of an out-of-range packet
// DROP_PARITY        | discarding the parity byte of that packet
module router_fsm_nch #(
  parameter int NUM_CH = 3,
  parameter int ADDR_W = 2
) (
  input  logic            clock,
  input  logic            resetn,
  router_fsm_nch_if.slave bus
);
  localparam int                PAD_W     = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   LP_NUM_CH = (ADDR_W + 1)'(NUM_CH);

  typedef enum logic [3:0] {
    DECODE_ADDRESS     = 4'd0,
    LOAD_FIRST_DATA    = 4'd1,
    LOAD_DATA          = 4'd2,
    WAIT_TILL_EMPTY    = 4'd3,
    CHECK_PARITY_ERROR = 4'd4,
    LOAD_PARITY        = 4'd5,
    FIFO_FULL_STATE    = 4'd6,
    LOAD_AFTER_FULL    = 4'd7,
    DROP_PACKET        = 4'd8,
    DROP_PARITY        = 4'd9
  } state_e;

  state_e            r_ps;
  state_e            w_ns;
  logic [ADDR_W-1:0] r_dest;
  logic              r_drop_first;
  logic [PAD_W-1:0]  w_empty_pad;
  logic [PAD_W-1:0]  w_soft_pad;
  logic              w_addr_oor;
  logic              w_owns_dest;

  // Pad per-channel flags to the full address space so any address indexes safely.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_pad_used
    assign w_empty_pad[g] = bus.fifo_empty[g];
    assign w_soft_pad[g]  = bus.soft_reset[g];
  end
  for (genvar g = NUM_CH; g < PAD_W; g++) begin : g_pad_unused
    assign w_empty_pad[g] = 1'b0;
    assign w_soft_pad[g]  = 1'b0;
  end

  assign w_addr_oor  = ({1'b0, bus.data_in} >= LP_NUM_CH);
  assign w_owns_dest = !(r_ps inside {DECODE_ADDRESS, DROP_PACKET, DROP_PARITY});

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_ps <= DECODE_ADDRESS;
    end else begin
      r_ps <= w_ns;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_dest       <= '0;
      r_drop_first <= 1'b0;
    end else begin
      if (r_ps == DECODE_ADDRESS && bus.pkt_valid) begin
        r_dest <= bus.data_in;
      end
      r_drop_first <= (r_ps == DECODE_ADDRESS) && bus.pkt_valid && w_addr_oor;
    end
  end

  always_comb begin
    w_ns = r_ps;
    case (r_ps)
      DECODE_ADDRESS: begin
        if (!bus.pkt_valid)                w_ns = DECODE_ADDRESS;
        else if (w_addr_oor)               w_ns = DROP_PACKET;
        else if (w_empty_pad[bus.data_in]) w_ns = LOAD_FIRST_DATA;
        else                               w_ns = WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: w_ns = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       w_ns = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_ns = LOAD_PARITY;
        else                     w_ns = LOAD_DATA;
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_pad[r_dest]) w_ns = LOAD_FIRST_DATA;
        else                     w_ns = WAIT_TILL_EMPTY;
      end
      LOAD_PARITY: w_ns = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        if (bus.fifo_full) w_ns = FIFO_FULL_STATE;
        else               w_ns = DECODE_ADDRESS;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) w_ns = LOAD_AFTER_FULL;
        else                w_ns = FIFO_FULL_STATE;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)           w_ns = DECODE_ADDRESS;
        else if (bus.low_packet_valid) w_ns = LOAD_PARITY;
        else                           w_ns = LOAD_DATA;
      end
      DROP_PACKET: begin
        if (!bus.pkt_valid) w_ns = DROP_PARITY;
        else                w_ns = DROP_PACKET;
      end
      DROP_PARITY: w_ns = DECODE_ADDRESS;
      default:     w_ns = DECODE_ADDRESS;
    endcase
    // Read-timeout soft reset only matters while a real destination is owned.
    if (w_owns_dest && w_soft_pad[r_dest]) begin
      w_ns = DECODE_ADDRESS;
    end
  end

  always_comb begin
    bus.detect_add    = 1'b0;
    bus.lfd_state     = 1'b0;
    bus.ld_state      = 1'b0;
    bus.laf_state     = 1'b0;
    bus.full_state    = 1'b0;
    bus.write_enb_reg = 1'b0;
    bus.rst_int_reg   = 1'b0;
    bus.busy          = 1'b0;
    bus.drop_state    = 1'b0;
    bus.addr_err      = 1'b0;
    case (r_ps)
      DECODE_ADDRESS:  bus.detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        bus.lfd_state = 1'b1;
        bus.busy      = 1'b1;
      end
      LOAD_DATA: begin
        bus.ld_state      = 1'b1;
        bus.write_enb_reg = 1'b1;
      end
      WAIT_TILL_EMPTY: bus.busy = 1'b1;
      CHECK_PARITY_ERROR: begin
        bus.rst_int_reg = 1'b1;
        bus.busy        = 1'b1;
      end
      LOAD_PARITY: begin
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      FIFO_FULL_STATE: begin
        bus.full_state = 1'b1;
        bus.busy       = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        bus.laf_state     = 1'b1;
        bus.write_enb_reg = 1'b1;
        bus.busy          = 1'b1;
      end
      DROP_PACKET: begin
        bus.drop_state = 1'b1;
        bus.addr_err   = r_drop_first;
      end
      DROP_PARITY: bus.drop_state = 1'b1;
      default:     bus.detect_add = 1'b0;
    endcase
  end

  assign bus.dest = r_dest;
endmodule

// File: tb/tb_router_fsm_nch.sv
// Scoreboard bench: a 3-channel and a 4-channel controller share one stimulus
// stream; a spec-level packet model predicts every cycle's outputs.
module tb_router_fsm_nch;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  router_fsm_nch_if #(.NUM_CH(3), .ADDR_W(2)) bus3 ();
  router_fsm_nch_if #(.NUM_CH(4), .ADDR_W(2)) bus4 ();

  router_fsm_nch #(.NUM_CH(3), .ADDR_W(2)) dut3 (.clock(clock), .resetn(resetn), .bus(bus3));
  router_fsm_nch #(.NUM_CH(4), .ADDR_W(2)) dut4 (.clock(clock), .resetn(resetn), .bus(bus4));

  typedef enum int {M_DA, M_LFD, M_LD, M_WTE, M_CPE, M_LP, M_FULL, M_LAF, M_DROP, M_DPAR} m_e;

  typedef struct {
    m_e st;
    int dest;
    bit first;
  } mst_t;

  typedef struct {
    bit       rstn;
    bit       pv;
    int       din;
    bit       full;
    bit [3:0] empty;
    bit [3:0] sr;
    bit       pd;
    bit       lpv;
  } stim_t;

  typedef struct packed {
    logic       da, lfd, ld, laf, full, wen, rint, busy, drop, aerr;
    logic [1:0] dest;
  } out_t;

  typedef struct {
    out_t exp;
    m_e   st;
    int   cyc;
  } ent_t;

  ent_t q3[$];
  ent_t q4[$];
  mst_t ms3, ms4;
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Packet-level rules: who owns a destination, where each byte goes.
  function automatic mst_t step(input int nch, input mst_t s, input stim_t x);
    mst_t n;
    n = s;
    n.first = 1'b0;
    if (!x.rstn) begin
      n.st = M_DA;
      n.dest = 0;
      return n;
    end
    if (s.st == M_DA && x.pv) n.dest = x.din;
    if (!(s.st inside {M_DA, M_DROP, M_DPAR}) && x.sr[s.dest]) begin
      n.st = M_DA;
      return n;
    end
    case (s.st)
      M_DA: if (x.pv) begin
        if (x.din >= nch) begin
          n.st = M_DROP;
          n.first = 1'b1;
        end else n.st = x.empty[x.din] ? M_LFD : M_WTE;
      end
      M_LFD:  n.st = M_LD;
      M_LD:   n.st = x.full ? M_FULL : (!x.pv ? M_LP : M_LD);
      M_WTE:  n.st = x.empty[s.dest] ? M_LFD : M_WTE;
      M_LP:   n.st = M_CPE;
      M_CPE:  n.st = x.full ? M_FULL : M_DA;
      M_FULL: n.st = x.full ? M_FULL : M_LAF;
      M_LAF:  n.st = x.pd ? M_DA : (x.lpv ? M_LP : M_LD);
      M_DROP: n.st = x.pv ? M_DROP : M_DPAR;
      M_DPAR: n.st = M_DA;
      default: n.st = M_DA;
    endcase
    return n;
  endfunction

  function automatic out_t exp_out(input mst_t s);
    out_t o;
    o.da   = (s.st == M_DA);
    o.lfd  = (s.st == M_LFD);
    o.ld   = (s.st == M_LD);
    o.laf  = (s.st == M_LAF);
    o.full = (s.st == M_FULL);
    o.wen  = (s.st inside {M_LD, M_LP, M_LAF});
    o.rint = (s.st == M_CPE);
    o.busy = (s.st inside {M_LFD, M_WTE, M_LP, M_CPE, M_FULL, M_LAF});
    o.drop = (s.st inside {M_DROP, M_DPAR});
    o.aerr = (s.st == M_DROP) && s.first;
    o.dest = 2'(s.dest);
    return o;
  endfunction

  function automatic stim_t idle();
    stim_t x;
    x.rstn = 1'b1; x.pv = 1'b0; x.din = 0; x.full = 1'b0;
    x.empty = 4'hF; x.sr = 4'h0; x.pd = 1'b0; x.lpv = 1'b0;
    return x;
  endfunction

  task automatic run(input stim_t x);
    ent_t e;
    @(negedge clock);
    #1;
    resetn = x.rstn;
    bus3.pkt_valid = x.pv;        bus4.pkt_valid = x.pv;
    bus3.data_in = 2'(x.din);     bus4.data_in = 2'(x.din);
    bus3.fifo_full = x.full;      bus4.fifo_full = x.full;
    bus3.fifo_empty = x.empty[2:0]; bus4.fifo_empty = x.empty;
    bus3.soft_reset = x.sr[2:0];  bus4.soft_reset = x.sr;
    bus3.parity_done = x.pd;      bus4.parity_done = x.pd;
    bus3.low_packet_valid = x.lpv; bus4.low_packet_valid = x.lpv;
    @(posedge clock);
    cyc++;
    ms3 = step(3, ms3, x);
    ms4 = step(4, ms4, x);
    e.cyc = cyc;
    e.st = ms3.st; e.exp = exp_out(ms3); q3.push_back(e);
    e.st = ms4.st; e.exp = exp_out(ms4); q4.push_back(e);
  endtask

  task automatic do_reset();
    stim_t x;
    x = idle();
    x.rstn = 1'b0;
    run(x);
  endtask

  // pv/din shorthand for a byte; other inputs idle except as overridden later.
  task automatic byte_in(input bit pv, input int din);
    stim_t x;
    x = idle();
    x.pv = pv;
    x.din = din;
    run(x);
  endtask

  task automatic check(input string name, input out_t act, input ent_t e);
    n_checks++;
    if (act === e.exp) n_pass++;
    else $display("FAIL %s cyc=%0d model=%s actual=%b required=%b (da lfd ld laf full wen rint busy drop aerr dest)",
                  name, e.cyc, e.st.name(), act, e.exp);
  endtask

  function automatic out_t act3();
    out_t o;
    o = {bus3.detect_add, bus3.lfd_state, bus3.ld_state, bus3.laf_state, bus3.full_state,
         bus3.write_enb_reg, bus3.rst_int_reg, bus3.busy, bus3.drop_state, bus3.addr_err, bus3.dest};
    return o;
  endfunction

  function automatic out_t act4();
    out_t o;
    o = {bus4.detect_add, bus4.lfd_state, bus4.ld_state, bus4.laf_state, bus4.full_state,
         bus4.write_enb_reg, bus4.rst_int_reg, bus4.busy, bus4.drop_state, bus4.addr_err, bus4.dest};
    return o;
  endfunction

  always @(negedge clock) begin
    ent_t e;
    if (q3.size() > 0) begin
      e = q3.pop_front();
      check("ch3_outputs", act3(), e);
    end
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check("ch4_outputs", act4(), e);
    end
  end

  initial begin
    stim_t x;
    ms3.st = M_DA; ms3.dest = 0; ms3.first = 1'b0;
    ms4 = ms3;
    x = idle();
    bus3.pkt_valid = 0; bus4.pkt_valid = 0;
    bus3.data_in = '0; bus4.data_in = '0;
    bus3.fifo_full = 0; bus4.fifo_full = 0;
    bus3.fifo_empty = '1; bus4.fifo_empty = '1;
    bus3.soft_reset = '0; bus4.soft_reset = '0;
    bus3.parity_done = 0; bus4.parity_done = 0;
    bus3.low_packet_valid = 0; bus4.low_packet_valid = 0;

    // Normal packet to ch1: header, 3 payload bytes, parity.
    do_reset(); do_reset();
    byte_in(1, 1); byte_in(1, 0); byte_in(1, 0); byte_in(1, 0); byte_in(0, 0);
    byte_in(0, 0); byte_in(0, 0); byte_in(0, 0);

    // ch2 busy draining; ch0/ch1 going non-empty must not matter.
    do_reset();
    x = idle(); x.pv = 1; x.din = 2; x.empty = 4'b1011; run(x);
    x = idle(); x.pv = 1; x.empty = 4'b1011; run(x); run(x);
    x = idle(); x.pv = 1; x.empty = 4'b0100; run(x);
    byte_in(1, 0); byte_in(0, 0); byte_in(0, 0); byte_in(0, 0); byte_in(0, 0);

    // Out-of-range header on the 3-channel unit, in-range on the 4-channel unit.
    do_reset();
    byte_in(1, 3); byte_in(1, 1); byte_in(1, 2); byte_in(1, 3); byte_in(1, 0);
    byte_in(0, 0); byte_in(0, 0); byte_in(0, 0); byte_in(0, 0); byte_in(0, 0);

    // FIFO full stall, released with low_packet_valid.
    do_reset();
    byte_in(1, 0); byte_in(1, 0);
    x = idle(); x.pv = 1; x.full = 1; run(x); run(x); run(x);
    x = idle(); x.lpv = 1; run(x); run(x);
    byte_in(0, 0); byte_in(0, 0); byte_in(0, 0);

    // full and !pkt_valid together in LOAD_DATA, then parity_done out of LAF.
    do_reset();
    byte_in(1, 1); byte_in(1, 0);
    x = idle(); x.full = 1; run(x);
    x = idle(); x.pd = 1; run(x); run(x); run(x);

    // Soft reset on a foreign channel is ignored, on the owned one it aborts.
    do_reset();
    x = idle(); x.pv = 1; x.din = 0; x.empty = 4'b0000; run(x);
    x.pv = 0; x.sr = 4'b0010; run(x); run(x);
    x.sr = 4'b0001; run(x);
    x = idle(); run(x);

    // Reset mid LOAD_DATA.
    do_reset();
    byte_in(1, 1); byte_in(1, 0); byte_in(1, 0); byte_in(1, 0);
    do_reset(); byte_in(0, 0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      x.rstn  = ($urandom_range(0, 299) != 0);
      x.pv    = ($urandom_range(0, 9) < 8);
      x.din   = int'($urandom_range(0, 3));
      x.full  = ($urandom_range(0, 99) < 15);
      x.empty = 4'($urandom);
      x.sr    = '0;
      for (int b = 0; b < 4; b++) x.sr[b] = ($urandom_range(0, 99) < 2);
      x.pd    = ($urandom_range(0, 9) < 3);
      x.lpv   = ($urandom_range(0, 9) < 3);
      run(x);
    end

    repeat (3) @(negedge clock);
    #2;
    n_checks++;
    if (q3.size() == 0 && q4.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain actual=%0d/%0d pending required=0/0", q3.size(), q4.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
